// File: rtl/som_seq_pkg.sv
// Shared state codes, phase/scan-order codes and the learning-rate helper
// for the SOM phase sequencer.
package som_seq_pkg;

   typedef logic [2:0] seq_state_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_TRAIN    = 3'd2;
   localparam logic [2:0] ST_MIN_PREP = 3'd3;
   localparam logic [2:0] ST_FIND_MIN = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   localparam logic PHASE_TRAIN    = 1'b0;
   localparam logic PHASE_FIND_MIN = 1'b1;

   localparam logic [1:0] MODE_RASTER     = 2'd0;
   localparam logic [1:0] MODE_SERPENTINE = 2'd1;
   localparam logic [1:0] MODE_COLUMN     = 2'd2;
   localparam logic [1:0] MODE_REVERSE    = 2'd3;

   // Learning-rate shift saturates at the 3-bit ceiling.
   function automatic logic [2:0] lr_sat(input int unsigned base, input int unsigned ep);
      int unsigned sum;
      sum = base + ep;
      if (sum > 32'd7) begin
         return 3'd7;
      end else begin
         return sum[2:0];
      end
   endfunction

   function automatic logic phase_of(input seq_state_t st);
      if (st == ST_FIND_MIN) begin
         return PHASE_FIND_MIN;
      end else begin
         return PHASE_TRAIN;
      end
   endfunction

endpackage

// File: rtl/som_seq_counter.sv
// Loadable, saturating down-counter with zero flag and hold enable;
// clr_i is a synchronous clear that overrides everything else.
module som_seq_counter
   import som_seq_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         hold_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (hold_i) begin
         cnt_d = cnt_q;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != {W{1'b0}})) begin
         cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/som_phase_sequencer.sv
// Phase FSM for the SOM compression datapath: TRAIN epochs then one FIND_MIN pass.
// Optional feature macro: SOM_LR_DECAY_EN (learning-rate shift grows with epoch).
module som_phase_sequencer
   import som_seq_pkg::*;
#(
   parameter int NUM_PIXELS    = 4096,
   parameter int EPOCHS        = 4,
   parameter int EPOCH_W       = 4,
   parameter int FILL_CYCLES   = 2,
   parameter int LR_SHIFT_INIT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               pause,
   output logic               phase,
   output logic               phase_next,
   output logic               addr_clr,
   output logic [1:0]         mode,
   output logic [EPOCH_W-1:0] epoch,
   output logic               epoch_done,
   output logic [2:0]         lr_shift,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = $clog2(FILL_CYCLES + NUM_PIXELS + 1);

   seq_state_t         state_q, state_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_nx_s;
   logic [1:0]         mode_q, mode_d;
   logic               phase_q, busy_q, done_q, addr_clr_q;
   logic               cnt_zero_s, cnt_load_s, cnt_dec_s;
   logic [CNT_W-1:0]   cnt_load_val_s;
   logic               idle_like_s, last_epoch_s, train_end_s, launch_s;

   assign idle_like_s  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign last_epoch_s = (epoch_q == EPOCH_W'(EPOCHS - 1));
   assign train_end_s  = (state_q == ST_TRAIN) && cnt_zero_s;
   assign launch_s     = idle_like_s && start;
   assign epoch_nx_s   = epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1};

   // Beat counter: TRAIN counts fill + pixel beats, FIND_MIN counts NUM_PIXELS down to 0 inclusive.
   assign cnt_load_s     = (state_q == ST_LOAD) || (state_q == ST_MIN_PREP);
   assign cnt_load_val_s = (state_q == ST_LOAD) ? CNT_W'(FILL_CYCLES + NUM_PIXELS - 1)
                                                : CNT_W'(NUM_PIXELS);
   assign cnt_dec_s      = (state_q == ST_TRAIN) || (state_q == ST_FIND_MIN);

   som_seq_counter #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (abort),
      .hold_i     (pause),
      .load_i     (cnt_load_s),
      .load_val_i (cnt_load_val_s),
      .dec_i      (cnt_dec_s),
      .zero_o     (cnt_zero_s)
   );

   // Next state: abort beats pause, pause beats start.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else if (pause) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: state_d = start ? ST_LOAD : state_q;
            ST_LOAD:          state_d = ST_TRAIN;
            ST_TRAIN: begin
               if (cnt_zero_s) begin
                  state_d = last_epoch_s ? ST_MIN_PREP : ST_LOAD;
               end else begin
                  state_d = state_q;
               end
            end
            ST_MIN_PREP:      state_d = ST_FIND_MIN;
            ST_FIND_MIN:      state_d = cnt_zero_s ? ST_DONE : state_q;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      epoch_d = epoch_q;
      mode_d  = mode_q;
      if (abort || (!pause && launch_s)) begin
         epoch_d = {EPOCH_W{1'b0}};
         mode_d  = MODE_RASTER;
      end else if (!pause && train_end_s && !last_epoch_s) begin
         epoch_d = epoch_nx_s;
         mode_d  = epoch_nx_s[1:0];
      end else begin
         epoch_d = epoch_q;
         mode_d  = mode_q;
      end
   end

   // Status flags are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         epoch_q    <= {EPOCH_W{1'b0}};
         mode_q     <= MODE_RASTER;
         phase_q    <= PHASE_TRAIN;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_clr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         epoch_q    <= epoch_d;
         mode_q     <= mode_d;
         phase_q    <= phase_of(state_d);
         busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         done_q     <= (state_d == ST_DONE);
         addr_clr_q <= (state_d == ST_LOAD) || (state_d == ST_MIN_PREP);
      end
   end

`ifdef SOM_LR_DECAY_EN
   logic [2:0] lr_q, lr_d;

   always_comb begin
      lr_d = lr_q;
      if (abort || (!pause && launch_s)) begin
         lr_d = 3'(LR_SHIFT_INIT);
      end else if (!pause && train_end_s && !last_epoch_s) begin
         lr_d = lr_sat(32'(LR_SHIFT_INIT), 32'(epoch_nx_s));
      end else begin
         lr_d = lr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lr_q <= 3'(LR_SHIFT_INIT);
      end else begin
         lr_q <= lr_d;
      end
   end

   assign lr_shift = lr_q;
`else
   assign lr_shift = 3'(LR_SHIFT_INIT);
`endif

   assign phase      = phase_q;
   assign phase_next = phase_of(state_d);
   assign addr_clr   = addr_clr_q & ~pause;
   assign epoch_done = train_end_s & ~pause;
   assign mode       = mode_q;
   assign epoch      = epoch_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_som_phase_sequencer.sv
// Self-checking bench: directed runs plus randomized start/abort/pause/reset
// compared against a timeline model of the sequencer.
module tb_som_phase_sequencer;

   localparam int NP    = 8;
   localparam int EP    = 2;
   localparam int EW    = 4;
   localparam int FILL  = 2;
   localparam int LRI   = 6;
   localparam int L     = 1 + FILL + NP;   // LOAD + TRAIN cycles per epoch
   localparam int EL    = EP * L;          // timeline index of MIN_PREP
   localparam int TOTAL = EL + 1 + NP + 1; // busy cycles per run

   logic          clk = 1'b0;
   logic          rst, start, abort, pause;
   logic          phase, phase_next, addr_clr, epoch_done, busy, done;
   logic [1:0]    mode;
   logic [EW-1:0] epoch;
   logic [2:0]    lr_shift;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: run flag, timeline position within the run, done flag.
   bit m_run, m_done;
   int m_t;

   int n_ac, n_ed, n_ph;
   logic [1:0] ed_mode[$];

   som_phase_sequencer #(
      .NUM_PIXELS(NP), .EPOCHS(EP), .EPOCH_W(EW), .FILL_CYCLES(FILL), .LR_SHIFT_INIT(LRI)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
      .phase(phase), .phase_next(phase_next), .addr_clr(addr_clr), .mode(mode),
      .epoch(epoch), .epoch_done(epoch_done), .lr_shift(lr_shift), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void mstep(input bit r, input int tt, input bit d,
                                 input bit st, input bit ab, input bit pa,
                                 output bit r2, output int t2, output bit d2);
      r2 = r; t2 = tt; d2 = d;
      if (ab) begin
         r2 = 1'b0; t2 = 0; d2 = 1'b0;
      end else if (pa) begin
         r2 = r;
      end else if (!r) begin
         if (st) begin
            r2 = 1'b1; t2 = 0; d2 = 1'b0;
         end
      end else begin
         t2 = tt + 1;
         if (t2 == TOTAL) begin
            r2 = 1'b0; t2 = 0; d2 = 1'b1;
         end
      end
   endfunction

   function automatic int ep_of(input bit r, input int tt, input bit d);
      if (r) return (tt < EL) ? tt / L : EP - 1;
      else if (d) return EP - 1;
      else return 0;
   endfunction

   function automatic int lr_of(input int e);
`ifdef SOM_LR_DECAY_EN
      return (LRI + e > 7) ? 7 : LRI + e;
`else
      return LRI + 0 * e;
`endif
   endfunction

   task automatic check_outputs();
      bit r2, d2;
      int t2, e;
      bit exp_ac, exp_ed;
      e = ep_of(m_run, m_t, m_done);
      mstep(m_run, m_t, m_done, start, abort, pause, r2, t2, d2);
      exp_ac = m_run && !pause && ((m_t < EL) ? (m_t % L == 0) : (m_t == EL));
      exp_ed = m_run && !pause && (m_t < EL) && (m_t % L == L - 1);
      check_eq("busy", busy, m_run);
      check_eq("done", done, m_done);
      check_eq("phase", phase, m_run && (m_t > EL));
      check_eq("phase_next", phase_next, r2 && (t2 > EL));
      check_eq("addr_clr", addr_clr, exp_ac);
      check_eq("epoch_done", epoch_done, exp_ed);
      check_eq("epoch", epoch, e);
      check_eq("mode", mode, e % 4);
      check_eq("lr_shift", lr_shift, lr_of(e));
   endtask

   // Called at posedge+1: apply inputs, check, cross the edge, advance the model.
   task automatic tick(input bit st, input bit ab, input bit pa);
      start = st; abort = ab; pause = pa;
      #2;
      check_outputs();
      if (addr_clr) n_ac++;
      if (phase) n_ph++;
      if (epoch_done) begin
         n_ed++;
         ed_mode.push_back(mode);
      end
      @(posedge clk);
      #1;
      mstep(m_run, m_t, m_done, st, ab, pa, m_run, m_t, m_done);
   endtask

   task automatic run_clean(input int pause_at, input bit hold_st, output int edges);
      n_ac = 0; n_ed = 0; n_ph = 0;
      ed_mode.delete();
      tick(1'b1, 1'b0, 1'b0);
      edges = 1;
      while (!done && edges < 200) begin
         tick(hold_st, 1'b0, (edges >= pause_at) && (edges < pause_at + 5));
         edges++;
      end
   endtask

   task automatic reset_pulse();
      rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
      m_run = 1'b0; m_t = 0; m_done = 1'b0;
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int lat;
      rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
      m_run = 1'b0; m_t = 0; m_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_pulse();

      // Clean run: timing, pulse counts, scan order per epoch.
      run_clean(1000, 1'b0, lat);
      check_eq("latency_clean", lat, TOTAL + 1);
      check_eq("addr_clr_count", n_ac, 3);
      check_eq("epoch_done_count", n_ed, 2);
      check_eq("phase_cycles", n_ph, NP + 1);
      check_eq("ed_mode0", (ed_mode.size() > 0) ? ed_mode[0] : 2'd3, 0);
      check_eq("ed_mode1", (ed_mode.size() > 1) ? ed_mode[1] : 2'd3, 1);

      // Pause five cycles inside TRAIN of epoch 1.
      run_clean(15, 1'b0, lat);
      check_eq("latency_pause", lat, TOTAL + 1 + 5);
      check_eq("pause_addr_clr_count", n_ac, 3);
      check_eq("pause_epoch_done_count", n_ed, 2);

      // Abort during FIND_MIN, then a full rerun.
      tick(1'b1, 1'b0, 1'b0);
      repeat (25) tick(1'b0, 1'b0, 1'b0);
      check_eq("in_find_min", phase, 1);
      tick(1'b0, 1'b1, 1'b0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_epoch", epoch, 0);
      run_clean(1000, 1'b0, lat);
      check_eq("latency_rerun", lat, TOTAL + 1);

      // Start held high: no restart while busy, immediate relaunch from DONE.
      run_clean(1000, 1'b1, lat);
      check_eq("latency_held", lat, TOTAL + 1);
      tick(1'b1, 1'b0, 1'b0);
      check_eq("relaunch_busy", busy, 1);
      tick(1'b0, 1'b1, 1'b0);

      // Randomized start/abort/pause with occasional mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 350) begin
            reset_pulse();
         end else begin
            tick(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 7) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
